ex_stage_pipe: RTL
==================

Name: ex_stage_pipe

Overview:
- Parametrised, registered execute stage for the RV32I-style core.
- Sits between decode/operand-read and the memory stage.
- Computes ALU results, resolves JAL/JALR/branches, and builds load/store requests for the memory stage.
- Uses valid/ready on both sides with a one-entry output register.
- Wrong-path instructions are squashed by an epoch bit; a held redirect request to IF completes with an ack handshake.

Parameters:
- XLEN, 32, datapath width. Legal values: 32, 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  7  major opcode.
- in_funct3  in  3  sub-operation.
- in_alt  in  1  SUB/SRA select (funct7 bit 5).
- in_mext  in  1  M-extension select (funct7 bit 0).
- in_n1  in  XLEN  operand 1 (rs1).
- in_n2  in  XLEN  operand 2 (rs2, immediate for OP-IMM/LOAD, link value for JAL/JALR, result for LUI/AUIPC).
- in_imm  in  XLEN  store offset.
- in_tgt  in  XLEN  precomputed jump/branch target (JALR: base offset).
- in_rd  in  5  destination register.
- in_we  in  1  register-write request.
- in_epoch  in  1  epoch tag of the instruction.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream accepts.
- out_res  out  XLEN  ALU result / memory address.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable.
- out_mem_e  out  5  memory request {en, len[1:0], wr, unsigned}; len 0=byte, 1=half, 3=word.
- out_mem_data  out  XLEN  store data.
- out_illegal  out  1  unsupported opcode/funct.
- redir_valid  out  1  PC redirect request to IF.
- redir_pc  out  XLEN  redirect target.
- redir_ack  in  1  IF accepted redirect.
- epoch  out  1  current epoch.

Behaviour:
- Reset: all out_* = 0, redir_valid = 0, redir_pc = 0, epoch = 0, state RUN. Reset mid-redirect abandons the redirect.
- States:
  - RUN: in_ready = !out_valid || out_ready.
  - REDIR: in_ready = 0.
  - RUN -> REDIR when a taken control-flow instruction is accepted.
  - REDIR -> RUN on the clock edge where redir_ack = 1. redir_valid deasserts the next cycle.
- Accept means in_valid && in_ready.
  - Accepted with in_epoch != epoch: squashed; out_valid is 0 next cycle and nothing is emitted.
  - Otherwise: result registered; out_valid = 1 next cycle. Latency 1 cycle.
- Output register holds while out_valid && !out_ready. If out_ready = 1 and no accept, out_valid clears.
- LUI/AUIPC (0110111/0010111): res = n2.
- OP/OP-IMM (0110011/0010011):
  - funct3 000: add; sub only for OP with alt = 1.
  - 001: shift left by n2[SHW-1:0].
  - 010: signed slt; 011: unsigned sltu.
  - 100/110/111: xor/or/and.
  - 101: srl (alt = 0) or sra (alt = 1).
  - Results are 0/1 zero-extended where applicable.
- JAL (1101111): res = n2, we = in_we; redir_pc = in_tgt.
- JALR (1100111): res = n2, we = in_we; redir_pc = (in_tgt + n1) with bit 0 cleared.
- Branch (1100011): we forced 0.
  - funct3 000/001/100/101/110/111 = eq/ne/lt/ge/ltu/geu.
  - Taken: redir_pc = in_tgt.
  - funct3 010/011: out_illegal = 1, not taken.
- Taken control flow: redir_valid = 1 and epoch toggles on the same edge the instruction is registered. The instruction itself is emitted normally.
- Store (0100011): res = n1 + in_imm, mem_data = n2, we forced 0.
  - funct3 000/001/010 → mem_e 5'b1_00_1_0 / 5'b1_01_1_0 / 5'b1_11_1_0.
  - Other funct3: illegal, mem_e = 0.
- Load (0000011): res = n1 + n2, mem_data = 0.
  - funct3 000/001/010/100/101 → len 0/1/3/0/1, wr = 0, unsigned = funct3[2].
  - Other funct3: illegal.
- Illegal or unknown opcode: res = 0, we = 0, mem_e = 0, out_illegal = 1. Still emitted.
- redir_ack while redir_valid = 0 is ignored.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: OP with in_mext = 1 and funct3 000/001/010/011 computes MUL (low XLEN bits), MULH (s×s high), MULHSU (s×u high), MULHU (u×u high). Still single-cycle latency. funct3 1xx (div/rem) is illegal.
- Undefined: every OP with in_mext = 1 is illegal (res 0, we 0, out_illegal 1).

Test Plan:
- ADD n1=5, n2=7, rd=3, we=1, epoch match → next cycle out_valid=1, res=12, rd=3, we=1; SUB alt=1 same operands → res=0xFFFFFFFE.
- SRA n1=0x80000000, n2=4 → res=0xF8000000; SLTU n1=1, n2=0xFFFFFFFF → res=1; SLT same operands → res=0.
- BEQ n1=n2=9, tgt=0x100 → redir_valid=1, redir_pc=0x100, epoch 0→1, in_ready=0. Hold ack low 3 cycles, then redir_ack=1 → redir_valid=0 next cycle. A following instruction with in_epoch=0 is accepted and squashed.
- JALR n1=0x203, tgt=4, n2=0x44 → res=0x44, redir_pc=0x206. out_ready=0 for 2 cycles keeps out_res stable and in_ready=0.
- LH n1=0x1000, n2=2 → res=0x1002, mem_e=5'b10100; SB funct3 000, n1=0x10, imm=1, n2=0xAB → res=0x11, mem_e=5'b10010, mem_data=0xAB, we=0.
- EX_MUL_EN: MULHU 0xFFFFFFFF×2 → res=1. Without the macro, same stimulus → out_illegal=1, res=0. Assert rst during REDIR → redir_valid=0, epoch=0 next cycle.

Source files
------------

// File: rtl/ex_stage_pipe_if.sv
// Handshake and data bundle between operand-read, the execute stage, memory stage and IF redirect.
// master drives instructions and accepts results; slave is the execute stage itself.
interface ex_stage_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_op;
    logic [2:0]      in_funct3;
    logic            in_alt;
    logic            in_mext;
    logic [XLEN-1:0] in_n1;
    logic [XLEN-1:0] in_n2;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_tgt;
    logic [4:0]      in_rd;
    logic            in_we;
    logic            in_epoch;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd;
    logic            out_we;
    logic [4:0]      out_mem_e;
    logic [XLEN-1:0] out_mem_data;
    logic            out_illegal;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ack;
    logic            epoch;

    modport master (
        output in_valid, in_op, in_funct3, in_alt, in_mext, in_n1, in_n2, in_imm,
               in_tgt, in_rd, in_we, in_epoch, out_ready, redir_ack,
        input  in_ready, out_valid, out_res, out_rd, out_we, out_mem_e, out_mem_data,
               out_illegal, redir_valid, redir_pc, epoch
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_alt, in_mext, in_n1, in_n2, in_imm,
               in_tgt, in_rd, in_we, in_epoch, out_ready, redir_ack,
        output in_ready, out_valid, out_res, out_rd, out_we, out_mem_e, out_mem_data,
               out_illegal, redir_valid, redir_pc, epoch
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// Registered RV32I/RV64I execute stage: ALU, branch/jump resolution, load/store request build.
// Define EX_MUL_EN to add single-cycle MUL/MULH/MULHSU/MULHU; otherwise M-extension ops are illegal.
module ex_stage_pipe #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst,
    ex_stage_pipe_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;

    logic [0:0]             state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [XLEN-1:0]        out_res_q;
    logic [4:0]             out_rd_q;
    logic                   out_we_q;
    logic [4:0]             out_mem_e_q;
    logic [XLEN-1:0]        out_mem_data_q;
    logic                   out_illegal_q;
    logic                   redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]        redir_pc_q, redir_pc_d;
    logic                   epoch_q, epoch_d;

    logic [XLEN-1:0]        n1, n2;
    logic signed [XLEN-1:0] n1_s, n2_s;
    logic [SHW-1:0]         sh;
    logic [2:0]             f3;
    logic [XLEN-1:0]        jalr_sum;
    logic                   in_ready, accept, live;

    logic [XLEN-1:0]        res_d, mem_data_d, tgt_d;
    logic [4:0]             mem_e_d;
    logic                   we_d, illegal_d, taken;

    assign n1       = bus.in_n1;
    assign n2       = bus.in_n2;
    assign n1_s     = bus.in_n1;
    assign n2_s     = bus.in_n2;
    assign sh       = bus.in_n2[SHW-1:0];
    assign f3       = bus.in_funct3;
    assign jalr_sum = bus.in_tgt + n1;

    assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    // Wrong-path instructions still consume the handshake but never reach the output register.
    assign live     = accept && (bus.in_epoch == epoch_q);

`ifdef EX_MUL_EN
    logic                   mul_sa, mul_sb;
    logic [2*XLEN-1:0]      mul_a, mul_b, mul_p;

    assign mul_sa = (f3 == 3'b001) || (f3 == 3'b010);
    assign mul_sb = (f3 == 3'b001);
    assign mul_a  = {{XLEN{mul_sa & n1[XLEN-1]}}, n1};
    assign mul_b  = {{XLEN{mul_sb & n2[XLEN-1]}}, n2};
    assign mul_p  = mul_a * mul_b;
`endif

    always_comb begin
        res_d      = '0;
        we_d       = 1'b0;
        mem_e_d    = '0;
        mem_data_d = '0;
        illegal_d  = 1'b0;
        taken      = 1'b0;
        tgt_d      = bus.in_tgt;
        case (bus.in_op)
            OP_LUI, OP_AUIPC: begin
                res_d = n2;
                we_d  = bus.in_we;
            end
            OP_REG, OP_IMM: begin
                if ((bus.in_op == OP_REG) && bus.in_mext) begin
`ifdef EX_MUL_EN
                    if (f3[2]) begin
                        illegal_d = 1'b1;
                    end else begin
                        res_d = (f3 == 3'b000) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
                        we_d  = bus.in_we;
                    end
`else
                    illegal_d = 1'b1;
`endif
                end else begin
                    we_d = bus.in_we;
                    case (f3)
                        3'b000:  res_d = ((bus.in_op == OP_REG) && bus.in_alt) ? n1 - n2 : n1 + n2;
                        3'b001:  res_d = n1 << sh;
                        3'b010:  res_d = XLEN'(n1_s < n2_s);
                        3'b011:  res_d = XLEN'(n1 < n2);
                        3'b100:  res_d = n1 ^ n2;
                        3'b101:  res_d = bus.in_alt ? XLEN'(n1_s >>> sh) : n1 >> sh;
                        3'b110:  res_d = n1 | n2;
                        default: res_d = n1 & n2;
                    endcase
                end
            end
            OP_JAL: begin
                res_d = n2;
                we_d  = bus.in_we;
                taken = 1'b1;
            end
            OP_JALR: begin
                res_d = n2;
                we_d  = bus.in_we;
                taken = 1'b1;
                tgt_d = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BR: begin
                case (f3)
                    3'b000:  taken = (n1 == n2);
                    3'b001:  taken = (n1 != n2);
                    3'b100:  taken = (n1_s < n2_s);
                    3'b101:  taken = !(n1_s < n2_s);
                    3'b110:  taken = (n1 < n2);
                    3'b111:  taken = !(n1 < n2);
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_STORE: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
                    res_d      = n1 + bus.in_imm;
                    mem_data_d = n2;
                    mem_e_d    = {1'b1, (f3[1] ? 2'b11 : {1'b0, f3[0]}), 1'b1, 1'b0};
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                    f3 == 3'b100 || f3 == 3'b101) begin
                    res_d   = n1 + n2;
                    we_d    = bus.in_we;
                    mem_e_d = {1'b1, (f3[1] ? 2'b11 : {1'b0, f3[0]}), 1'b0, f3[2]};
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        epoch_d       = epoch_q;
        out_valid_d   = out_valid_q;
        if (live) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // A taken redirect can only be accepted in RUN, so the two branches never overlap.
        if (live && taken) begin
            state_d       = REDIR;
            redir_valid_d = 1'b1;
            redir_pc_d    = tgt_d;
            epoch_d       = ~epoch_q;
        end else if ((state_q == REDIR) && bus.redir_ack) begin
            state_d       = RUN;
            redir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            out_valid_q    <= 1'b0;
            out_res_q      <= '0;
            out_rd_q       <= '0;
            out_we_q       <= 1'b0;
            out_mem_e_q    <= '0;
            out_mem_data_q <= '0;
            out_illegal_q  <= 1'b0;
            redir_valid_q  <= 1'b0;
            redir_pc_q     <= '0;
            epoch_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            epoch_q       <= epoch_d;
            if (live) begin
                out_res_q      <= res_d;
                out_rd_q       <= bus.in_rd;
                out_we_q       <= we_d;
                out_mem_e_q    <= mem_e_d;
                out_mem_data_q <= mem_data_d;
                out_illegal_q  <= illegal_d;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_res      = out_res_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_we       = out_we_q;
    assign bus.out_mem_e    = out_mem_e_q;
    assign bus.out_mem_data = out_mem_data_q;
    assign bus.out_illegal  = out_illegal_q;
    assign bus.redir_valid  = redir_valid_q;
    assign bus.redir_pc     = redir_pc_q;
    assign bus.epoch        = epoch_q;
endmodule
